// File: rtl/gray_sync_decoder.sv
// -----------------------------------------------------------------------------
// gray_sync_decoder
//
// Brings a Gray-coded count from a foreign clock domain into the CLK domain
// through a SYNC_STAGES-deep flop synchronizer, converts it to binary and
// checks that every accepted update is a single +/-1 step (modulo wrap).
// Illegal jumps are still accepted (the local count resyncs to them) but are
// flagged on STEP_ERR and counted in a saturating error counter.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   GRAY_IN    in   Gray code from the foreign domain (asynchronous to CLK)
//   CLR_ERR    in   synchronous clear of ERR_CNT (wins over a same-cycle error)
//   BIN_OUT    out  last accepted value, binary
//   GRAY_SYNC  out  last accepted value, Gray
//   VALID      out  one-cycle pulse when BIN_OUT/GRAY_SYNC update
//   DIR        out  direction of last legal step (1 up, 0 down)
//   STEP_ERR   out  one-cycle pulse when an accepted update is not +/-1
//   ERR_CNT    out  saturating count of STEP_ERR events
//   PRIMED     out  high once the post-reset baseline has been captured
//
// All outputs are registered; there is no combinational path from GRAY_IN.
// -----------------------------------------------------------------------------
module gray_sync_decoder #(
   parameter int NUM_PIN     = 3,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_PIN:0]   GRAY_IN,
   input  logic               CLR_ERR,
   output logic [NUM_PIN:0]   BIN_OUT,
   output logic [NUM_PIN:0]   GRAY_SYNC,
   output logic               VALID,
   output logic               DIR,
   output logic               STEP_ERR,
   output logic [ERR_W-1:0]   ERR_CNT,
   output logic               PRIMED
);

   localparam int                 FILL_W    = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
   localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(SYNC_STAGES - 1);
   localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
   localparam logic [NUM_PIN:0]   CNT_ONE   = (NUM_PIN + 1)'(1);
   localparam logic [ERR_W-1:0]   ERR_ONE   = ERR_W'(1);
   localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PRIME = 2'd1,
      TRACK = 2'd2
   } state_e;

   state_e                 state_q;
   logic [FILL_W-1:0]      fill_q;
   logic [NUM_PIN:0]       sync_q [SYNC_STAGES];
   logic [NUM_PIN:0]       bin_q;
   logic [NUM_PIN:0]       gray_q;
   logic                   valid_q;
   logic                   dir_q;
   logic                   step_err_q;
   logic [ERR_W-1:0]       err_cnt_q;
   logic                   primed_q;

   logic [NUM_PIN:0]       s_gray;
   logic [NUM_PIN:0]       bin_d;
   logic                   changed;
   logic                   is_up;
   logic                   is_down;
   logic                   err_event;

   // B[MSB] = G[MSB]; each lower bit folds in the bit above it.
   function automatic logic [NUM_PIN:0] gray2bin(input logic [NUM_PIN:0] g);
      logic [NUM_PIN:0] b;
      b[NUM_PIN] = g[NUM_PIN];
      for (int i = NUM_PIN - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Step classification against the last accepted value. Arithmetic is in
   // NUM_PIN+1 bits, so all-ones -> 0 counts as up and 0 -> all-ones as down.
   // NOTE: every signal gets a value on every pass through this block, so no
   // latch is inferred.
   always_comb begin
      s_gray    = sync_q[SYNC_STAGES-1];
      bin_d     = gray2bin(s_gray);
      changed   = (s_gray != gray_q);
      is_up     = (bin_d == (bin_q + CNT_ONE));
      is_down   = (bin_d == (bin_q - CNT_ONE));
      err_event = (state_q == TRACK) && changed && !is_up && !is_down;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others (the synchronizer chain relies
   // on this to shift one stage per clock).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: the synchronizer flops are reset too; a stale pre-reset
         // sample must never reach the baseline capture.
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         state_q    <= FILL;
         fill_q     <= '0;
         bin_q      <= '0;
         gray_q     <= '0;
         valid_q    <= 1'b0;
         dir_q      <= 1'b0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
         primed_q   <= 1'b0;
      end else begin
         // Plain flop chain, no logic between stages.
         sync_q[0] <= GRAY_IN;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end

         valid_q    <= 1'b0;
         step_err_q <= 1'b0;

         if (CLR_ERR) begin
            err_cnt_q <= '0;
         end else if (err_event && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_ONE;
         end

         unique case (state_q)
            // Wait until the last synchronizer stage holds a real sample.
            FILL: begin
               if (fill_q == FILL_LAST) begin
                  state_q <= PRIME;
               end else begin
                  fill_q <= fill_q + FILL_ONE;
               end
            end

            // Baseline capture; never checked for step legality.
            PRIME: begin
               gray_q   <= s_gray;
               bin_q    <= bin_d;
               valid_q  <= 1'b1;
               primed_q <= 1'b1;
               state_q  <= TRACK;
            end

            // Every change is accepted; only the flags differ.
            TRACK: begin
               if (changed) begin
                  gray_q  <= s_gray;
                  bin_q   <= bin_d;
                  valid_q <= 1'b1;
                  if (is_up) begin
                     dir_q <= 1'b1;
                  end else if (is_down) begin
                     dir_q <= 1'b0;
                  end else begin
                     step_err_q <= 1'b1;
                  end
               end
            end

            default: state_q <= FILL;
         endcase
      end
   end

   assign BIN_OUT   = bin_q;
   assign GRAY_SYNC = gray_q;
   assign VALID     = valid_q;
   assign DIR       = dir_q;
   assign STEP_ERR  = step_err_q;
   assign ERR_CNT   = err_cnt_q;
   assign PRIMED    = primed_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_sync_decoder
//
// Directed test of gray_sync_decoder (NUM_PIN=3, SYNC_STAGES=2). Two copies
// share all inputs: one with the default 8-bit error counter and one with a
// 2-bit counter to exercise saturation. Expected values are hand-computed
// from the Gray-to-binary table for each vector.
// -----------------------------------------------------------------------------
module tb_gray_sync_decoder;

   logic       CLK;
   logic       RST_N;
   logic [3:0] GRAY_IN;
   logic       CLR_ERR;

   logic [3:0] BIN_OUT,   BIN_OUT_E2;
   logic [3:0] GRAY_SYNC, GRAY_SYNC_E2;
   logic       VALID,     VALID_E2;
   logic       DIR,       DIR_E2;
   logic       STEP_ERR,  STEP_ERR_E2;
   logic [7:0] ERR_CNT;
   logic [1:0] ERR_CNT_E2;
   logic       PRIMED,    PRIMED_E2;

   int n_checks = 0;
   int n_errors = 0;

   gray_sync_decoder #(.NUM_PIN(3), .SYNC_STAGES(2), .ERR_W(8)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .GRAY_IN   (GRAY_IN),
      .CLR_ERR   (CLR_ERR),
      .BIN_OUT   (BIN_OUT),
      .GRAY_SYNC (GRAY_SYNC),
      .VALID     (VALID),
      .DIR       (DIR),
      .STEP_ERR  (STEP_ERR),
      .ERR_CNT   (ERR_CNT),
      .PRIMED    (PRIMED)
   );

   gray_sync_decoder #(.NUM_PIN(3), .SYNC_STAGES(2), .ERR_W(2)) dut_e2 (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .GRAY_IN   (GRAY_IN),
      .CLR_ERR   (CLR_ERR),
      .BIN_OUT   (BIN_OUT_E2),
      .GRAY_SYNC (GRAY_SYNC_E2),
      .VALID     (VALID_E2),
      .DIR       (DIR_E2),
      .STEP_ERR  (STEP_ERR_E2),
      .ERR_CNT   (ERR_CNT_E2),
      .PRIMED    (PRIMED_E2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 ns later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_errs(input string tag, input logic [7:0] e8, input logic [1:0] e2);
      check({tag, "_errcnt"},    32'(ERR_CNT),    32'(e8));
      check({tag, "_errcnt_e2"}, 32'(ERR_CNT_E2), 32'(e2));
   endtask

   // Assert reset between edges, confirm everything clears without a clock,
   // then release and follow the FILL/PRIME sequence to the baseline pulse.
   task automatic reset_prime(input string tag, input logic [3:0] g, input logic [3:0] exp_bin);
      GRAY_IN = g;
      RST_N   = 1'b0;
      #2;
      check({tag, "_rst_bin"},    32'(BIN_OUT),   32'd0);
      check({tag, "_rst_gray"},   32'(GRAY_SYNC), 32'd0);
      check({tag, "_rst_valid"},  32'(VALID),     32'd0);
      check({tag, "_rst_dir"},    32'(DIR),       32'd0);
      check({tag, "_rst_step"},   32'(STEP_ERR),  32'd0);
      check({tag, "_rst_primed"}, 32'(PRIMED),    32'd0);
      check_errs({tag, "_rst"}, 8'd0, 2'd0);
      tick();
      RST_N = 1'b1;
      tick();
      check({tag, "_fill1_valid"},  32'(VALID),  32'd0);
      check({tag, "_fill1_primed"}, 32'(PRIMED), 32'd0);
      tick();
      check({tag, "_fill2_valid"},  32'(VALID),  32'd0);
      check({tag, "_fill2_primed"}, 32'(PRIMED), 32'd0);
      tick();
      check({tag, "_prime_valid"},  32'(VALID),     32'd1);
      check({tag, "_prime_bin"},    32'(BIN_OUT),   32'(exp_bin));
      check({tag, "_prime_gray"},   32'(GRAY_SYNC), 32'(g));
      check({tag, "_prime_primed"}, 32'(PRIMED),    32'd1);
      check({tag, "_prime_step"},   32'(STEP_ERR),  32'd0);
      check({tag, "_prime_dir"},    32'(DIR),       32'd0);
      tick();
      check({tag, "_post_valid"}, 32'(VALID), 32'd0);
   endtask

   // Change GRAY_IN and expect the update exactly three edges later.
   // With clr set, CLR_ERR is held across that third edge only.
   task automatic step_to(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                          input logic exp_dir, input logic exp_step, input logic clr);
      GRAY_IN = g;
      tick();
      check({tag, "_e1_valid"}, 32'(VALID), 32'd0);
      tick();
      check({tag, "_e2_valid"}, 32'(VALID), 32'd0);
      if (clr) CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check({tag, "_valid"}, 32'(VALID),     32'd1);
      check({tag, "_bin"},   32'(BIN_OUT),   32'(exp_bin));
      check({tag, "_gray"},  32'(GRAY_SYNC), 32'(g));
      check({tag, "_dir"},   32'(DIR),       32'(exp_dir));
      check({tag, "_step"},  32'(STEP_ERR),  32'(exp_step));
      check({tag, "_bin_e2"}, 32'(BIN_OUT_E2), 32'(exp_bin));
      tick();
      check({tag, "_e4_valid"}, 32'(VALID),    32'd0);
      check({tag, "_e4_step"},  32'(STEP_ERR), 32'd0);
      check({tag, "_e4_bin"},   32'(BIN_OUT),  32'(exp_bin));
   endtask

   initial begin
      RST_N   = 1'b1;
      CLR_ERR = 1'b0;
      GRAY_IN = 4'b0110;
      #1;

      // Baseline 0110 -> bin 4, then single steps up and down.
      reset_prime("base", 4'b0110, 4'd4);
      step_to("up5",   4'b0111, 4'd5, 1'b1, 1'b0, 1'b0);
      step_to("down4", 4'b0110, 4'd4, 1'b0, 1'b0, 1'b0);
      check_errs("steps", 8'd0, 2'd0);

      // Wrap in both directions from bin 15.
      reset_prime("wrapb", 4'b1000, 4'd15);
      step_to("wrap_up",   4'b0000, 4'd0,  1'b1, 1'b0, 1'b0);
      step_to("wrap_down", 4'b1000, 4'd15, 1'b0, 1'b0, 1'b0);
      check_errs("wrap", 8'd0, 2'd0);

      // Jumps: DIR holds, counters advance; the 2-bit copy saturates at 3.
      reset_prime("jumpb", 4'b0111, 4'd5);
      step_to("jump9", 4'b1101, 4'd9, 1'b0, 1'b1, 1'b0);
      check_errs("jump9", 8'd1, 2'd1);
      step_to("up10", 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0);
      check_errs("up10", 8'd1, 2'd1);
      step_to("jump0", 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0);
      check_errs("jump0", 8'd2, 2'd2);
      step_to("jump4", 4'b0110, 4'd4, 1'b1, 1'b1, 1'b0);
      check_errs("jump4", 8'd3, 2'd3);
      step_to("jump9b", 4'b1101, 4'd9, 1'b1, 1'b1, 1'b0);
      check_errs("sat", 8'd4, 2'd3);

      // Fifth jump coincides with CLR_ERR: clear wins, other outputs unaffected.
      step_to("jumpclr", 4'b0000, 4'd0, 1'b1, 1'b1, 1'b1);
      check_errs("clr", 8'd0, 2'd0);

      // Build some state, then reset mid-operation and re-prime at bin 9.
      step_to("up1",   4'b0001, 4'd1, 1'b1, 1'b0, 1'b0);
      step_to("jump4c", 4'b0110, 4'd4, 1'b1, 1'b1, 1'b0);
      check_errs("pre_rst", 8'd1, 2'd1);
      reset_prime("midrst", 4'b1101, 4'd9);
      check_errs("midrst", 8'd0, 2'd0);
      step_to("after_rst", 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
